// File: rtl/mult_operand_loader.sv
// Operand front end for the radix-4 multiplier: buffers signed A/B pairs in a small FIFO and
// feeds each pair onto the datapath byte bus with load strobes, then starts the controller.
module mult_operand_loader #(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   inValid,
  output logic                   inReady,
  input  logic [15:0]            inA,
  input  logic [15:0]            inB,
  input  logic                   busyMult,
  input  logic                   doneMult,
  output logic [7:0]             dataOut,
  output logic                   loadLsbA,
  output logic                   loadMsbA,
  output logic                   loadLsbB,
  output logic                   loadMsbB,
  output logic                   startMult,
  output logic [$clog2(DEPTH):0] count,
  output logic [2:0]             dbg_state
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LDA_L = 3'd1,
    LDA_M = 3'd2,
    LDB_L = 3'd3,
    LDB_M = 3'd4,
    START = 3'd5,
    WAIT  = 3'd6
  } state_t;

  state_t state_q, state_d;

  logic [15:0]   mem_a [DEPTH];
  logic [15:0]   mem_b [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [15:0]   head_a;
  logic [15:0]   head_b;
  logic          push;
  logic          pop;

  // Handshake: a pair transfers on every rising edge where inValid && inReady; inReady depends
  // only on the registered occupancy, so it never combinationally follows inValid.
  assign inReady   = (count < CW'(DEPTH));
  assign push      = inValid && inReady;
  assign pop       = (state_q == START);
  assign head_a    = mem_a[rd_ptr];
  assign head_b    = mem_b[rd_ptr];
  assign dbg_state = state_q;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_a[wr_ptr] <= inA;
      mem_b[wr_ptr] <= inB;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // busyMult only matters when deciding to begin a new pair; doneMult only releases WAIT.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if ((count != '0) && !busyMult) state_d = LDA_L;
      LDA_L:   state_d = LDA_M;
      LDA_M:   state_d = LDB_L;
      LDB_L:   state_d = LDB_M;
      LDB_M:   state_d = START;
      START:   state_d = WAIT;
      WAIT:    if (doneMult) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are flops loaded from the next state, so they always equal a decode of state_q.
  // The head entry is stable across the load sequence because it is only popped in START.
  always_ff @(posedge clk) begin
    if (rst) begin
      dataOut   <= 8'h00;
      loadLsbA  <= 1'b0;
      loadMsbA  <= 1'b0;
      loadLsbB  <= 1'b0;
      loadMsbB  <= 1'b0;
      startMult <= 1'b0;
    end else begin
      dataOut   <= 8'h00;
      loadLsbA  <= 1'b0;
      loadMsbA  <= 1'b0;
      loadLsbB  <= 1'b0;
      loadMsbB  <= 1'b0;
      startMult <= 1'b0;
      case (state_d)
        LDA_L: begin
          dataOut  <= head_a[7:0];
          loadLsbA <= 1'b1;
        end
        LDA_M: begin
          dataOut  <= head_a[15:8];
          loadMsbA <= 1'b1;
        end
        LDB_L: begin
          dataOut  <= head_b[7:0];
          loadLsbB <= 1'b1;
        end
        LDB_M: begin
          dataOut  <= head_b[15:8];
          loadMsbB <= 1'b1;
        end
        START: begin
          startMult <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

`ifndef SYNTHESIS
  a_strobe_onehot: assert property (@(posedge clk) disable iff (rst)
    $onehot0({loadLsbA, loadMsbA, loadLsbB, loadMsbB, startMult}));
  a_count_bound: assert property (@(posedge clk) disable iff (rst) count <= CW'(DEPTH));
  a_pop_nonempty: assert property (@(posedge clk) disable iff (rst) pop |-> (count != '0));
`endif

endmodule

// File: tb/tb_mult_operand_loader.sv
// Bench for mult_operand_loader: cycle-exact vector table, hand sequences for backpressure and
// reset, and a randomized stream checked against a queue-based model of the pair FIFO.
module tb_mult_operand_loader;

  localparam int DEPTH = 2;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk;
  logic          rst;
  logic          inValid;
  logic          inReady;
  logic [15:0]   inA;
  logic [15:0]   inB;
  logic          busyMult;
  logic          doneMult;
  logic [7:0]    dataOut;
  logic          loadLsbA;
  logic          loadMsbA;
  logic          loadLsbB;
  logic          loadMsbB;
  logic          startMult;
  logic [CW-1:0] count;
  logic [2:0]    dbg_state;

  typedef struct packed {
    logic          v;
    logic [15:0]   a;
    logic [15:0]   b;
    logic          busy;
    logic          done;
    logic [7:0]    e_data;
    logic [4:0]    e_strb;
    logic [CW-1:0] e_cnt;
    logic          e_rdy;
  } vec_t;

  vec_t        tbl[$];
  logic [31:0] exp_q[$];
  int          n_vec;
  int          n_err;
  logic [15:0] cap_a;
  logic [15:0] cap_b;
  logic [3:0]  cap_mask;

  mult_operand_loader #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .inValid   (inValid),
    .inReady   (inReady),
    .inA       (inA),
    .inB       (inB),
    .busyMult  (busyMult),
    .doneMult  (doneMult),
    .dataOut   (dataOut),
    .loadLsbA  (loadLsbA),
    .loadMsbA  (loadMsbA),
    .loadLsbB  (loadLsbB),
    .loadMsbB  (loadMsbB),
    .startMult (startMult),
    .count     (count),
    .dbg_state (dbg_state)
  );

  // clock / watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(input logic v, input logic [15:0] a, input logic [15:0] b,
                              input logic busy, input logic done, input logic [7:0] d,
                              input logic [4:0] s, input logic [CW-1:0] c, input logic r);
    vec_t t;
    t.v = v; t.a = a; t.b = b; t.busy = busy; t.done = done;
    t.e_data = d; t.e_strb = s; t.e_cnt = c; t.e_rdy = r;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // scoreboard: rebuild each pair from the bytes seen on the bus and match it at startMult
  task automatic sample();
    logic [4:0] strb;
    strb = {loadLsbA, loadMsbA, loadLsbB, loadMsbB, startMult};
    check("count_vs_model", 32'(count), 32'(exp_q.size()));
    check("strobe_onehot", 32'($onehot0(strb)), 32'd1);
    if (loadLsbA) begin cap_a[7:0]  = dataOut; cap_mask[0] = 1'b1; end
    if (loadMsbA) begin cap_a[15:8] = dataOut; cap_mask[1] = 1'b1; end
    if (loadLsbB) begin cap_b[7:0]  = dataOut; cap_mask[2] = 1'b1; end
    if (loadMsbB) begin cap_b[15:8] = dataOut; cap_mask[3] = 1'b1; end
    if (startMult) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL start_without_pair: got startMult=1, expected no pending pair start");
      end else begin
        check("pair_bytes", {cap_a, cap_b}, exp_q.pop_front());
        check("all_bytes_loaded", 32'(cap_mask), 32'hF);
      end
      cap_mask = '0;
    end
  endtask

  // driver: entered and left at a falling edge; inputs apply at the rising edge in between
  task automatic cycle(input logic v, input logic [15:0] a, input logic [15:0] b,
                       input logic busy, input logic done, output logic acc);
    inValid  = v;
    inA      = a;
    inB      = b;
    busyMult = busy;
    doneMult = done;
    acc      = v && inReady;
    @(posedge clk);
    #1;
    if (acc) exp_q.push_back({a, b});
    @(negedge clk);
    sample();
  endtask

  task automatic do_reset(input string tag);
    rst      = 1'b1;
    inValid  = 1'b0;
    inA      = '0;
    inB      = '0;
    busyMult = 1'b0;
    doneMult = 1'b0;
    @(posedge clk);
    #1;
    exp_q.delete();
    cap_mask = '0;
    @(negedge clk);
    rst = 1'b0;
    check({tag, "_count"}, 32'(count), 32'd0);
    check({tag, "_ready"}, 32'(inReady), 32'd1);
    check({tag, "_data"}, 32'(dataOut), 32'd0);
    check({tag, "_strobes"}, 32'({loadLsbA, loadMsbA, loadLsbB, loadMsbB, startMult}), 32'd0);
  endtask

  // answers every startMult with a doneMult two cycles later until the model queue drains
  task automatic drain(input string name);
    logic d;
    logic sp;
    logic acc;
    logic fin;
    sp  = 1'b0;
    fin = 1'b0;
    for (int i = 0; i < 200 && !fin; i++) begin
      d  = sp;
      sp = startMult;
      cycle(1'b0, 16'h0, 16'h0, 1'b0, d, acc);
      if (d && exp_q.size() == 0) fin = 1'b1;
    end
    check(name, 32'(fin), 32'd1);
  endtask

  initial begin
    logic acc;
    logic d;
    logic sp;
    logic v;
    logic bz;
    logic fin;
    int   n;
    int   sent;
    int   starts;
    logic [15:0] cur_a;
    logic [15:0] cur_b;
    vec_t t;

    n_vec    = 0;
    n_err    = 0;
    cap_a    = '0;
    cap_b    = '0;
    cap_mask = '0;
    rst      = 1'b1;
    inValid  = 1'b0;
    inA      = '0;
    inB      = '0;
    busyMult = 1'b0;
    doneMult = 1'b0;
    @(negedge clk);
    do_reset("por");

    // strobe order {loadLsbA, loadMsbA, loadLsbB, loadMsbB, startMult}
    tbl.push_back(mk(1, 16'h1234, 16'hFFFE, 0, 0, 8'h00, 5'b00000, 1, 1));
    tbl.push_back(mk(0, 16'h0000, 16'h0000, 0, 0, 8'h34, 5'b10000, 1, 1));
    tbl.push_back(mk(0, 16'h0000, 16'h0000, 0, 0, 8'h12, 5'b01000, 1, 1));
    tbl.push_back(mk(0, 16'h0000, 16'h0000, 0, 0, 8'hFE, 5'b00100, 1, 1));
    tbl.push_back(mk(0, 16'h0000, 16'h0000, 0, 0, 8'hFF, 5'b00010, 1, 1));
    tbl.push_back(mk(0, 16'h0000, 16'h0000, 0, 0, 8'h00, 5'b00001, 1, 1));
    tbl.push_back(mk(0, 16'h0000, 16'h0000, 0, 0, 8'h00, 5'b00000, 0, 1));
    tbl.push_back(mk(0, 16'h0000, 16'h0000, 0, 1, 8'h00, 5'b00000, 0, 1));
    tbl.push_back(mk(0, 16'h0000, 16'h0000, 0, 1, 8'h00, 5'b00000, 0, 1));
    tbl.push_back(mk(1, 16'h8001, 16'h7F00, 1, 0, 8'h00, 5'b00000, 1, 1));
    tbl.push_back(mk(0, 16'h0000, 16'h0000, 1, 0, 8'h00, 5'b00000, 1, 1));
    tbl.push_back(mk(0, 16'h0000, 16'h0000, 0, 0, 8'h01, 5'b10000, 1, 1));
    tbl.push_back(mk(0, 16'h0000, 16'h0000, 0, 0, 8'h80, 5'b01000, 1, 1));
    tbl.push_back(mk(0, 16'h0000, 16'h0000, 0, 0, 8'h00, 5'b00100, 1, 1));
    tbl.push_back(mk(0, 16'h0000, 16'h0000, 0, 1, 8'h7F, 5'b00010, 1, 1));
    tbl.push_back(mk(0, 16'h0000, 16'h0000, 0, 0, 8'h00, 5'b00001, 1, 1));
    tbl.push_back(mk(0, 16'h0000, 16'h0000, 0, 0, 8'h00, 5'b00000, 0, 1));
    tbl.push_back(mk(1, 16'hA5C3, 16'h0102, 0, 0, 8'h00, 5'b00000, 1, 1));
    tbl.push_back(mk(0, 16'h0000, 16'h0000, 0, 1, 8'h00, 5'b00000, 1, 1));
    tbl.push_back(mk(0, 16'h0000, 16'h0000, 0, 0, 8'hC3, 5'b10000, 1, 1));
    tbl.push_back(mk(0, 16'h0000, 16'h0000, 0, 0, 8'hA5, 5'b01000, 1, 1));
    tbl.push_back(mk(0, 16'h0000, 16'h0000, 0, 0, 8'h02, 5'b00100, 1, 1));
    tbl.push_back(mk(0, 16'h0000, 16'h0000, 0, 0, 8'h01, 5'b00010, 1, 1));
    tbl.push_back(mk(0, 16'h0000, 16'h0000, 0, 0, 8'h00, 5'b00001, 1, 1));
    tbl.push_back(mk(0, 16'h0000, 16'h0000, 0, 0, 8'h00, 5'b00000, 0, 1));
    tbl.push_back(mk(0, 16'h0000, 16'h0000, 0, 1, 8'h00, 5'b00000, 0, 1));

    foreach (tbl[i]) begin
      t = tbl[i];
      cycle(t.v, t.a, t.b, t.busy, t.done, acc);
      check($sformatf("row%0d", i),
            32'({dataOut, loadLsbA, loadMsbA, loadLsbB, loadMsbB, startMult, count, inReady}),
            32'({t.e_data, t.e_strb, t.e_cnt, t.e_rdy}));
    end

    // backpressure: third pair waits for the first pop, then pairs leave in push order
    cycle(1'b1, 16'h1111, 16'h2222, 1'b0, 1'b0, acc);
    check("full_ready_after_push1", 32'(inReady), 32'd1);
    cycle(1'b1, 16'h3333, 16'h4444, 1'b0, 1'b0, acc);
    check("full_ready_after_push2", 32'(inReady), 32'd0);
    n = 0;
    while (!startMult && n < 10) begin
      cycle(1'b1, 16'h5555, 16'h6666, 1'b0, 1'b0, acc);
      check("third_pair_held", 32'(acc), 32'd0);
      n++;
    end
    check("full_start_reached", 32'(startMult), 32'd1);
    check("full_ready_low_in_start", 32'(inReady), 32'd0);
    cycle(1'b1, 16'h5555, 16'h6666, 1'b0, 1'b0, acc);
    check("full_no_passthrough", 32'(acc), 32'd0);
    check("full_ready_after_pop", 32'(inReady), 32'd1);
    cycle(1'b1, 16'h5555, 16'h6666, 1'b0, 1'b0, acc);
    check("full_third_accepted", 32'(acc), 32'd1);
    cycle(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, acc);
    drain("full_drain");

    // reset in LDA_M with two pairs buffered
    cycle(1'b1, 16'hAAAA, 16'hBBBB, 1'b1, 1'b0, acc);
    cycle(1'b1, 16'hCCCC, 16'hDDDD, 1'b1, 1'b0, acc);
    check("rst_pre_count", 32'(count), 32'd2);
    cycle(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, acc);
    check("rst_pre_lda_l", 32'({loadLsbA, dataOut}), 32'h1AA);
    cycle(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, acc);
    check("rst_pre_lda_m", 32'({loadMsbA, dataOut}), 32'h1AA);
    do_reset("midop");
    starts = 0;
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, acc);
      starts += int'(startMult) + int'(loadLsbA);
    end
    check("no_activity_after_reset", 32'(starts), 32'd0);

    // randomized stream with gaps, occasional busy and immediate doneMult
    sent  = 0;
    sp    = 1'b0;
    fin   = 1'b0;
    cur_a = 16'h8000;
    cur_b = 16'h7FFF;
    for (int c = 0; c < 3000 && !fin; c++) begin
      d  = sp;
      sp = startMult;
      v  = (sent < 8) && ($urandom_range(0, 2) != 0);
      bz = ($urandom_range(0, 3) == 0);
      cycle(v, cur_a, cur_b, bz, d, acc);
      if (acc) begin
        sent++;
        cur_a = 16'($urandom);
        cur_b = 16'($urandom);
      end
      if (sent == 8 && exp_q.size() == 0 && d) fin = 1'b1;
    end
    check("stream_completed", 32'(fin), 32'd1);
    check("stream_sent", 32'(sent), 32'd8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
